// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: routes a valid/ready stream to one of four registered output channels.
// Define DEMUX_PKT_LOCK_EN to keep every beat of a packet on the channel chosen by its first beat.
module demux_1_4_stream #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_last,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_last
);
    logic [3:0] full;
    logic [1:0] dest;
    logic       accept;
`ifdef DEMUX_PKT_LOCK_EN
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;
    logic [0:0] state;
    logic [1:0] lock_sel;
    assign dest = (state == LOCKED) ? lock_sel : in_sel;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lock_sel <= '0;
        end else if (accept) begin
            if (state == IDLE && !in_last) begin
                state    <= LOCKED;
                lock_sel <= in_sel;
            end else if (state == LOCKED && in_last) begin
                state <= IDLE;
            end
        end
    end
`else
    assign dest = in_sel;
`endif
    // A full channel can still accept when it drains in the same cycle.
    assign in_ready  = !full[dest] || out_ready[dest];
    assign accept    = in_valid && in_ready;
    assign out_valid = full;
    for (genvar c = 0; c < 4; c++) begin : g_ch
        logic             load;
        logic             full_r;
        logic             last_r;
        logic [WIDTH-1:0] data_r;
        assign load = accept && (dest == 2'(c));
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                full_r <= 1'b0;
                last_r <= 1'b0;
                data_r <= '0;
            end else if (load) begin
                full_r <= 1'b1;
                last_r <= in_last;
                data_r <= in_data;
            end else if (out_ready[c]) begin
                full_r <= 1'b0;
            end
        end
        assign full[c]                     = full_r;
        assign out_last[c]                 = last_r;
        assign out_data[c*WIDTH +: WIDTH]  = data_r;
    end
endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb_demux_1_4_stream: scoreboard bench for demux_1_4_stream; expectations follow DEMUX_PKT_LOCK_EN.
module tb_demux_1_4_stream;
    localparam int W = 4;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic [1:0]     in_sel = '0;
    logic           in_last = 1'b0;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready = '0;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_last;
    int             nvec = 0;
    int             nerr = 0;
    logic [W:0]     sb [4][$];
    logic           mlocked = 1'b0;
    logic [1:0]     mlsel = '0;
    logic           acc;

    demux_1_4_stream #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; checks outputs, updates the model, advances one cycle.
    task automatic step(input logic v, input logic [W-1:0] d, input logic [1:0] s,
                        input logic l, input logic [3:0] ordy, output logic ac);
        logic [1:0] dest;
        logic       exp_rdy;
        logic [W:0] e;
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        in_last   = l;
        out_ready = ordy;
        #1;
        dest = s;
`ifdef DEMUX_PKT_LOCK_EN
        if (mlocked) dest = mlsel;
`endif
        exp_rdy = (sb[dest].size() == 0) || ordy[dest];
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        for (int c = 0; c < 4; c++) begin
            check($sformatf("out_valid[%0d]", c), 32'(out_valid[c]), 32'(sb[c].size() != 0));
            if (sb[c].size() != 0 && ordy[c]) begin
                e = sb[c].pop_front();
                check($sformatf("out_data[%0d]", c), 32'(out_data[c*W +: W]), 32'(e[W-1:0]));
                check($sformatf("out_last[%0d]", c), 32'(out_last[c]), 32'(e[W]));
            end
        end
        ac = v && exp_rdy;
        if (ac) begin
            sb[dest].push_back({l, d});
`ifdef DEMUX_PKT_LOCK_EN
            if (!mlocked && !l) begin
                mlocked = 1'b1;
                mlsel   = s;
            end else if (mlocked && l) begin
                mlocked = 1'b0;
            end
`endif
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [1:0]   s;
        logic         l;
        repeat (2) @(negedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst out_data", 32'(out_data), 32'h0);
        check("rst out_last", 32'(out_last), 32'h0);
        check("rst in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        // one beat per channel, all consumers ready
        for (int i = 0; i < 4; i++) step(1'b1, W'(4'hA + i), 2'(i), 1'b1, 4'hF, acc);
        repeat (2) step(1'b0, '0, '0, 1'b0, 4'hF, acc);
        // channel 2 stalled; channel 1 keeps flowing
        step(1'b1, 4'h3, 2'd2, 1'b1, 4'b1011, acc);
        step(1'b1, 4'h6, 2'd1, 1'b1, 4'b1011, acc);
        repeat (2) step(1'b1, 4'h5, 2'd2, 1'b1, 4'b1011, acc);
        step(1'b1, 4'h5, 2'd2, 1'b1, 4'b1111, acc);
        check("stalled beat accepted on drain", 32'(acc), 32'h1);
        step(1'b0, '0, '0, 1'b0, 4'hF, acc);
        // back-to-back stream to channel 1
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 2'd1, 1'b1, 4'hF, acc);
        step(1'b0, '0, '0, 1'b0, 4'hF, acc);
        // three-beat packet whose later beats ask for channel 0
        step(1'b1, 4'h7, 2'd3, 1'b0, 4'hF, acc);
        step(1'b1, 4'h9, 2'd0, 1'b0, 4'hF, acc);
        step(1'b1, 4'hE, 2'd0, 1'b1, 4'hF, acc);
        step(1'b1, 4'h2, 2'd0, 1'b1, 4'hF, acc);
        step(1'b0, '0, '0, 1'b0, 4'hF, acc);
        // async reset mid-packet with channels 0 and 3 full
        step(1'b1, 4'h4, 2'd3, 1'b1, 4'h0, acc);
        step(1'b1, 4'h8, 2'd0, 1'b0, 4'h0, acc);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'h0);
        check("async rst out_data", 32'(out_data), 32'h0);
        check("async rst in_ready", 32'(in_ready), 32'h1);
        for (int c = 0; c < 4; c++) sb[c].delete();
        mlocked = 1'b0;
        mlsel   = '0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 4'h1, 2'd2, 1'b1, 4'hF, acc);
        step(1'b0, '0, '0, 1'b0, 4'hF, acc);
        // random traffic with random backpressure; inputs held while stalled
        acc = 1'b1;
        d = '0;
        s = '0;
        l = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (acc) begin
                d = W'($urandom);
                s = 2'($urandom);
                l = ($urandom_range(0, 2) == 0);
            end
            step(1'b1, d, s, l, 4'($urandom), acc);
        end
        repeat (3) step(1'b0, '0, '0, 1'b0, 4'hF, acc);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
